// File: rtl/pio_debounce_irq.sv
// pio_debounce_irq: Avalon-MM parallel I/O with synchronised, debounced inputs,
// edge capture, a maskable level interrupt and an output register with set/clear.
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   avs_address/read/write      Avalon-MM slave, word addressed (8 registers)
//   avs_writedata/readdata      32-bit data; readdata registered, zero wait states
//   in_export                   asynchronous input pins
//   out_export                  output register
//   irq                         |(EDGE_CAP & IRQ_MASK), active-high level
module pio_debounce_irq #(
    parameter int IN_WIDTH     = 4,
    parameter int OUT_WIDTH    = 10,
    parameter int EDGE_TYPE    = 0,
    parameter int DB_TICKS     = 4,
    parameter int DB_DIV_RESET = 50000,
    parameter int OUT_RESET    = 0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  in_export,
    output logic [OUT_WIDTH-1:0] out_export,
    output logic                 irq
);
    localparam logic [3:0] DB_LAST = 4'(DB_TICKS - 1);

    logic [IN_WIDTH-1:0]       sync1_q, sync2_q, db_q, db_d, dly_q, cap_q, cap_d, mask_q, mask_d;
    logic [IN_WIDTH-1:0]       rise, fall, edges;
    logic [IN_WIDTH-1:0][3:0]  agree_q, agree_d;
    logic [OUT_WIDTH-1:0]      out_q, out_d;
    logic [15:0]               div_q, div_d, tcnt_q, tcnt_d;
    logic [31:0]               rdata_q, rdata_d, rmux;
    logic                      tick, we_out, we_mask, we_cap, we_set, we_clr, we_div;

    always_comb begin
        we_out  = avs_write && avs_address == 3'd1;
        we_mask = avs_write && avs_address == 3'd2;
        we_cap  = avs_write && avs_address == 3'd3;
        we_set  = avs_write && avs_address == 3'd4;
        we_clr  = avs_write && avs_address == 3'd5;
        we_div  = avs_write && avs_address == 3'd6;
        // Tick on wrap of 0..DB_DIV; a divider write restarts the count.
        tick    = tcnt_q == div_q;
        tcnt_d  = (we_div || tick) ? 16'd0 : tcnt_q + 16'd1;
        div_d   = we_div ? 16'(avs_writedata) : div_q;
        mask_d  = we_mask ? IN_WIDTH'(avs_writedata) : mask_q;
        out_d   = we_out ? OUT_WIDTH'(avs_writedata) :
                  we_set ? out_q | OUT_WIDTH'(avs_writedata) :
                  we_clr ? out_q & ~OUT_WIDTH'(avs_writedata) : out_q;
        agree_d = agree_q;
        db_d    = db_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (tick) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (agree_q[i] == DB_LAST) begin
                        db_d[i]    = sync2_q[i];
                        agree_d[i] = 4'd0;
                    end else begin
                        agree_d[i] = agree_q[i] + 4'd1;
                    end
                end else begin
                    agree_d[i] = 4'd0;
                end
            end
        end
        rise    = db_q & ~dly_q;
        fall    = ~db_q & dly_q;
        edges   = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
        // New edges are OR-ed after the clear so a simultaneous edge wins.
        cap_d   = (cap_q & ~(we_cap ? IN_WIDTH'(avs_writedata) : '0)) | edges;
        case (avs_address)
            3'd0:    rmux = 32'(db_q);
            3'd1:    rmux = 32'(out_q);
            3'd2:    rmux = 32'(mask_q);
            3'd3:    rmux = 32'(cap_q);
            3'd6:    rmux = 32'(div_q);
            default: rmux = 32'd0;
        endcase
        rdata_d = avs_read ? rmux : rdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            dly_q   <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            agree_q <= '0;
            out_q   <= OUT_WIDTH'(OUT_RESET);
            div_q   <= 16'(DB_DIV_RESET);
            tcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= in_export;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dly_q   <= db_q;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            agree_q <= agree_d;
            out_q   <= out_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign out_export   = out_q;
    assign irq          = |(cap_q & mask_q);
endmodule

// File: tb/tb_pio_debounce_irq.sv
// tb_pio_debounce_irq: scoreboard bench for pio_debounce_irq with default parameters.
module tb_pio_debounce_irq;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic [3:0]  in_export;
    logic [9:0]  out_export;
    logic        irq;

    pio_debounce_irq dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .in_export(in_export), .out_export(out_export), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    int passed = 0, total = 0;
    logic [31:0] exp_q[$];
    int          adr_q[$];
    logic        rd_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) rd_v <= 1'b0;
        else rd_v <= avs_read;

    always @(negedge clk_clk) begin
        int a;
        logic [31:0] e;
        if (rd_v) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
                a = adr_q.pop_front();
                e = exp_q.pop_front();
                check($sformatf("rd%0d", a), avs_readdata, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        cyc();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        avs_address = a;
        avs_read = 1'b1;
        exp_q.push_back(e);
        adr_q.push_back(int'(a));
        cyc();
        avs_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_reset_n = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        in_export = '0;
        idle(3);
        check("rst_out", 32'(out_export), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        reset_reset_n = 1'b1;
        cyc();
        rd(6, 32'd50000);
        rd(3, 32'd0);
        rd(2, 32'd0);
        rd(0, 32'd0);
        rd(7, 32'd0);
        wr(6, 32'd0);
        wr(2, 32'd1);
        rd(6, 32'd0);
        rd(2, 32'd1);
        // 3-cycle glitch is rejected
        in_export = 4'b0001;
        idle(3);
        in_export = 4'b0000;
        idle(10);
        rd(0, 32'd0);
        rd(3, 32'd0);
        check("glitch_irq", 32'(irq), 32'd0);
        // held input: DATA at cycle 6, EDGE_CAP/irq at cycle 7
        in_export = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("irq@%0d", k), 32'(irq), 32'(k >= 7));
            rd(0, 32'(k >= 6));
        end
        rd(3, 32'd1);
        // output register ops
        wr(1, 32'h0F0);
        check("out_wr", 32'(out_export), 32'h0F0);
        wr(4, 32'h003);
        check("out_set", 32'(out_export), 32'h0F3);
        rd(1, 32'h0F3);
        rd(4, 32'd0);
        wr(5, 32'h030);
        check("out_clr", 32'(out_export), 32'h0C3);
        wr(1, 32'hFFFF_FFFF);
        rd(1, 32'h3FF);
        wr(0, 32'hF);
        rd(0, 32'd1);
        // W1C racing a new edge: edge wins
        in_export = 4'b0000;
        idle(10);
        rd(0, 32'd0);
        rd(3, 32'd1);
        in_export = 4'b0001;
        idle(6);
        wr(3, 32'd1);
        rd(3, 32'd1);
        check("irq_pre_clr", 32'(irq), 32'd1);
        wr(3, 32'd1);
        check("irq_clr", 32'(irq), 32'd0);
        rd(3, 32'd0);
        // mask gates irq, takes effect next cycle
        wr(2, 32'd0);
        in_export = 4'b0011;
        idle(10);
        check("irq_masked", 32'(irq), 32'd0);
        rd(3, 32'd2);
        wr(2, 32'd2);
        check("irq_unmasked", 32'(irq), 32'd1);
        rd(2, 32'd2);
        // divider 9: latency 2 + 40 cycles within +-9
        wr(6, 32'd9);
        rd(6, 32'd9);
        in_export = 4'b0111;
        for (int k = 0; k < 56; k++) begin
            if (k == 32) rd(0, 32'd3);
            else if (k == 52) rd(0, 32'd7);
            else cyc();
        end
        // reset mid-debounce discards progress
        wr(6, 32'd0);
        in_export = 4'b0000;
        idle(10);
        rd(0, 32'd0);
        in_export = 4'b0001;
        idle(4);
        reset_reset_n = 1'b0;
        #1;
        check("rst2_irq", 32'(irq), 32'd0);
        check("rst2_out", 32'(out_export), 32'd0);
        idle(2);
        reset_reset_n = 1'b1;
        wr(6, 32'd0);
        for (int k = 1; k < 9; k++) rd(0, 32'(k >= 6));
        rd(3, 32'd1);
        idle(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
